// File: rtl/mem16_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem16_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Which requester currently owns (or last owned) the memory port.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DA = 1'b1
    } owner_t;

    // Memwrite encodings understood by the memory block.
    localparam logic [1:0] MEMW_NONE = 2'd0;
    localparam logic [1:0] MEMW_WORD = 2'd1;
    localparam logic [1:0] MEMW_HALF = 2'd3;

    // Memwrite code for a write of the given size.
    function automatic logic [1:0] memw_code(input logic half);
        return half ? MEMW_HALF : MEMW_WORD;
    endfunction

endpackage

// File: rtl/mem16_arbiter_if.sv
// Request/ack and memory/BUS signal bundle around the arbiter.
// slave: arbiter side; master: CPU front/back ends plus the memory/BUS model.
interface mem16_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;

    logic          da_req;
    logic          da_we;
    logic          da_half;
    logic [AW-1:0] da_addr;
    logic [DW-1:0] da_wdata;
    logic          da_ack;
    logic [DW-1:0] da_rdata;

    logic          mem_read;
    logic [1:0]    mem_write;
    logic [AW-1:0] mem_addr;
    logic          bus_oe;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    modport slave (
        input  if_req, if_addr, da_req, da_we, da_half, da_addr, da_wdata, bus_rdata,
        output if_ack, if_rdata, da_ack, da_rdata,
        output mem_read, mem_write, mem_addr, bus_oe, bus_wdata
    );

    modport master (
        output if_req, if_addr, da_req, da_we, da_half, da_addr, da_wdata, bus_rdata,
        input  if_ack, if_rdata, da_ack, da_rdata,
        input  mem_read, mem_write, mem_addr, bus_oe, bus_wdata
    );
endinterface

// File: rtl/mem16_arb_pick.sv
// Combinational winner select between IF and DA.
// Build option: define ARB_RR_EN for round-robin on contested cycles;
// otherwise DA has fixed priority over IF.
module mem16_arb_pick
    import mem16_pkg::*;
(
    input  logic   if_req,
    input  logic   da_req,
    input  owner_t rr_last,      // requester served most recently
    output logic   grant_valid,
    output owner_t grant
);

    assign grant_valid = if_req | da_req;

`ifdef ARB_RR_EN
    // Contested: the one not served last wins; uncontested: the lone requester.
    always_comb begin
        grant = OWN_IF;
        if (if_req && da_req) begin
            grant = (rr_last == OWN_DA) ? OWN_IF : OWN_DA;
        end else if (da_req) begin
            grant = OWN_DA;
        end
    end
`else
    // History plays no part in fixed priority.
    logic unused_rr_last;
    assign unused_rr_last = rr_last;

    // DA wins whenever it is requesting.
    always_comb begin
        grant = da_req ? OWN_DA : OWN_IF;
    end
`endif

endmodule

// File: rtl/mem16_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch (read-only)
// and data access (read/write). Each access holds addr/control for
// ACC_CYCLES clocks, captures read data on the last one, then pulses the
// owner's ack for a single cycle. Round-robin arbitration is selected with
// the ARB_RR_EN macro (see mem16_arb_pick); default is DA-over-IF priority.
module mem16_arbiter
    import mem16_pkg::*;
#(
    parameter int ACC_CYCLES = 4,   // 2..15
    parameter int AW         = 15,
    parameter int DW         = 32
)(
    input  logic           clk,
    input  logic           rst,
    mem16_arbiter_if.slave arb
);

    localparam logic [3:0] LAST_COUNT = 4'(ACC_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [3:0]    count_reg, count_next;
    owner_t        owner_reg, owner_next;
    owner_t        rr_reg,    rr_next;
    logic [AW-1:0] addr_reg,  addr_next;
    logic          we_reg,    we_next;
    logic          half_reg,  half_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] da_rdata_reg;

    logic          capture;
    logic          pick_valid;
    owner_t        pick_owner;
    logic          mem_read_c;
    logic [1:0]    mem_write_c;
    logic [AW-1:0] mem_addr_c;
    logic          bus_oe_c;
    logic [DW-1:0] bus_wdata_c;
    logic [1:0]    ack_vec;

    mem16_arb_pick u_pick (
        .if_req      (arb.if_req),
        .da_req      (arb.da_req),
        .rr_last     (rr_reg),
        .grant_valid (pick_valid),
        .grant       (pick_owner)
    );

    // Next-state, request latching and memory-side outputs; everything is
    // decoded from the state register so reset silences the port at once.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        owner_next  = owner_reg;
        rr_next     = rr_reg;
        addr_next   = addr_reg;
        we_next     = we_reg;
        half_next   = half_reg;
        wdata_next  = wdata_reg;
        capture     = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = MEMW_NONE;
        mem_addr_c  = '0;
        bus_oe_c    = 1'b0;
        bus_wdata_c = '0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = ACCESS;
                    count_next = '0;
                    owner_next = pick_owner;
                    if (pick_owner == OWN_DA) begin
                        addr_next  = arb.da_addr;
                        we_next    = arb.da_we;
                        half_next  = arb.da_half;
                        wdata_next = arb.da_wdata;
                    end else begin
                        addr_next  = arb.if_addr;
                        we_next    = 1'b0;
                        half_next  = 1'b0;
                        wdata_next = '0;
                    end
                end
            end

            ACCESS: begin
                mem_addr_c = addr_reg;
                if (we_reg) begin
                    mem_write_c = memw_code(half_reg);
                    bus_oe_c    = 1'b1;
                    bus_wdata_c = wdata_reg;
                end else begin
                    mem_read_c  = 1'b1;
                end
                if (count_reg == LAST_COUNT) begin
                    capture    = ~we_reg;
                    state_next = DONE;
                end else begin
                    count_next = count_reg + 4'd1;
                end
            end

            DONE: begin
                rr_next    = owner_reg;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched request copy and arbitration history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            owner_reg <= OWN_IF;
            rr_reg    <= OWN_IF;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            half_reg  <= 1'b0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            owner_reg <= owner_next;
            rr_reg    <= rr_next;
            addr_reg  <= addr_next;
            we_reg    <= we_next;
            half_reg  <= half_next;
            wdata_reg <= wdata_next;
        end
    end

    // Read data capture on the final access cycle; held until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_reg <= '0;
            da_rdata_reg <= '0;
        end else if (capture) begin
            if (owner_reg == OWN_IF) begin
                if_rdata_reg <= arb.bus_rdata;
            end else begin
                da_rdata_reg <= arb.bus_rdata;
            end
        end
    end

    // One ack per owner, high only in DONE; index follows the owner encoding.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign ack_vec[gi] = (state_reg == DONE) && (owner_reg == owner_t'(gi));
    end

    assign arb.if_ack    = ack_vec[0];
    assign arb.da_ack    = ack_vec[1];
    assign arb.if_rdata  = if_rdata_reg;
    assign arb.da_rdata  = da_rdata_reg;
    assign arb.mem_read  = mem_read_c;
    assign arb.mem_write = mem_write_c;
    assign arb.mem_addr  = mem_addr_c;
    assign arb.bus_oe    = bus_oe_c;
    assign arb.bus_wdata = bus_wdata_c;

endmodule

// File: tb/tb_mem16_arbiter.sv
// Scoreboard bench for mem16_arbiter: drivers push expected transactions per
// requester; a negedge monitor rebuilds each memory access from the pins,
// predicts the winner from the arbitration rule and checks it at the ack.
`timescale 1ns/1ps
module tb_mem16_arbiter;
    import mem16_pkg::*;

    localparam int ACC = 4;
    localparam int AW  = 15;
    localparam int DW  = 32;

    typedef struct {
        bit            we;
        bit            half;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem16_arbiter_if #(.AW(AW), .DW(DW)) arb_if ();

    mem16_arbiter #(.ACC_CYCLES(ACC), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    txn_t q_if[$];
    txn_t q_da[$];
    int   if_ack_cycles[$];
    int   last_ack_cyc = 0;

    logic          rd_fixed_en = 1'b0;
    logic [DW-1:0] rd_fixed    = '0;

    // Memory content seen on BUS for a read of a given address.
    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {a ^ 15'h5A3C, 2'b10, a};
    endfunction

    assign arb_if.bus_rdata = arb_if.mem_read ? (rd_fixed_en ? rd_fixed : word_of(arb_if.mem_addr)) : '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arbitration rule: who wins when the listed requesters are pending.
    function automatic owner_t model_pick(input bit r_if, input bit r_da, input owner_t last);
        if (r_if && r_da) begin
`ifdef ARB_RR_EN
            return (last == OWN_DA) ? OWN_IF : OWN_DA;
`else
            return (last == OWN_DA) ? OWN_DA : OWN_DA;
`endif
        end
        return r_da ? OWN_DA : OWN_IF;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit            active = 0, p_if = 0, p_da = 0, mem_on, have;
    int            act_len = 0, start_cyc = 0;
    logic [AW-1:0] act_addr;
    logic [1:0]    act_w;
    logic [DW-1:0] act_wd;
    owner_t        pred = OWN_IF, last_served = OWN_IF, who;
    txn_t          t;
    logic [1:0]    exp_w;

    // Rebuild accesses from the pins and retire one expectation per ack.
    always @(negedge clk) begin
        if (rst) begin
            active = 0; last_served = OWN_IF; p_if = 0; p_da = 0;
        end else begin
            cyc++;
            mem_on = arb_if.mem_read || (arb_if.mem_write != MEMW_NONE);
            chk("read_write_overlap", 32'(arb_if.mem_read && arb_if.mem_write != MEMW_NONE), 0);
            chk("ack_overlap", 32'(arb_if.if_ack && arb_if.da_ack), 0);
            chk("bus_oe_vs_write", 32'(arb_if.bus_oe), 32'(arb_if.mem_write != MEMW_NONE));
            chk("mem_write_legal", 32'(arb_if.mem_write != 2'd2), 1);
            if (mem_on && !active) begin
                active = 1; act_len = 1; start_cyc = cyc;
                act_addr = arb_if.mem_addr; act_w = arb_if.mem_write; act_wd = arb_if.bus_wdata;
                chk("access_without_request", 32'(p_if || p_da), 1);
                pred = model_pick(p_if, p_da, last_served);
            end else if (mem_on) begin
                act_len++;
                chk("mem_addr_stable", 32'(arb_if.mem_addr), 32'(act_addr));
                chk("mem_write_stable", 32'(arb_if.mem_write), 32'(act_w));
                chk("mem_read_stable", 32'(arb_if.mem_read), 32'(act_w == MEMW_NONE));
                chk("bus_wdata_stable", arb_if.bus_wdata, act_wd);
            end else begin
                chk("idle_mem_addr", 32'(arb_if.mem_addr), 0);
                chk("idle_bus_wdata", arb_if.bus_wdata, 0);
                if (active) begin
                    chk("access_length", act_len, ACC);
                    active = 0;
                end
            end
            if (arb_if.if_ack || arb_if.da_ack) begin
                who = arb_if.da_ack ? OWN_DA : OWN_IF;
                last_ack_cyc = cyc;
                if (who == OWN_IF) if_ack_cycles.push_back(cyc);
                chk("ack_owner", 32'(who), 32'(pred));
                chk("ack_after_access_start", cyc - start_cyc, ACC);
                have = (who == OWN_IF) ? (q_if.size() != 0) : (q_da.size() != 0);
                chk("ack_expected", 32'(have), 1);
                if (have) begin
                    if (who == OWN_IF) t = q_if.pop_front();
                    else               t = q_da.pop_front();
                    exp_w = t.we ? (t.half ? MEMW_HALF : MEMW_WORD) : MEMW_NONE;
                    chk("access_addr", 32'(act_addr), 32'(t.addr));
                    chk("access_kind", 32'(act_w), 32'(exp_w));
                    if (t.we)               chk("bus_wdata", act_wd, t.wdata);
                    else if (who == OWN_IF) chk("if_rdata", arb_if.if_rdata, t.rdata);
                    else                    chk("da_rdata", arb_if.da_rdata, t.rdata);
                end
                last_served = who;
            end
            p_if = arb_if.if_req;
            p_da = arb_if.da_req;
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ack(input bit is_da);
        int n = 0;
        bit got = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = is_da ? arb_if.da_ack : arb_if.if_ack;
        end
        if (!got) chk(is_da ? "da_ack_timeout" : "if_ack_timeout", 0, 1);
    endtask

    task automatic if_txn(input logic [AW-1:0] addr, input bit hold);
        txn_t e;
        e.we = 0; e.half = 0; e.addr = addr; e.wdata = '0;
        e.rdata = rd_fixed_en ? rd_fixed : word_of(addr);
        q_if.push_back(e);
        arb_if.if_addr = addr;
        arb_if.if_req  = 1'b1;
        wait_ack(1'b0);
        step();
        if (!hold) arb_if.if_req = 1'b0;
    endtask

    task automatic da_txn(input bit we, input bit half, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit hold);
        txn_t e;
        e.we = we; e.half = half; e.addr = addr; e.wdata = wdata;
        e.rdata = word_of(addr);
        q_da.push_back(e);
        arb_if.da_we = we; arb_if.da_half = half;
        arb_if.da_addr = addr; arb_if.da_wdata = wdata;
        arb_if.da_req = 1'b1;
        wait_ack(1'b1);
        step();
        if (!hold) arb_if.da_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        txn_t e;
        arb_if.if_req = 0; arb_if.if_addr = '0;
        arb_if.da_req = 0; arb_if.da_we = 0; arb_if.da_half = 0;
        arb_if.da_addr = '0; arb_if.da_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_ack", 32'(arb_if.if_ack), 0);
        chk("rst_da_ack", 32'(arb_if.da_ack), 0);
        chk("rst_mem_read", 32'(arb_if.mem_read), 0);
        chk("rst_mem_write", 32'(arb_if.mem_write), 0);
        chk("rst_mem_addr", 32'(arb_if.mem_addr), 0);
        chk("rst_bus_oe", 32'(arb_if.bus_oe), 0);
        chk("rst_bus_wdata", arb_if.bus_wdata, 0);
        chk("rst_if_rdata", arb_if.if_rdata, 0);
        chk("rst_da_rdata", arb_if.da_rdata, 0);
        rst = 0;
        repeat (2) step();

        // IF read of 0x0010 returning 0xDEADBEEF, ack ACC+2 cycles after req.
        rd_fixed = 32'hDEADBEEF; rd_fixed_en = 1;
        r = cyc;
        if_txn(15'h0010, 1'b0);
        chk("if_req_to_ack", last_ack_cyc - r, ACC + 2);
        rd_fixed_en = 0;
        repeat (2) step();

        // DA halfword write, then the port goes quiet.
        da_txn(1'b1, 1'b1, 15'h0003, 32'h0000ABCD, 1'b0);
        chk("after_write_mem_write", 32'(arb_if.mem_write), 0);
        chk("after_write_bus_oe", 32'(arb_if.bus_oe), 0);
        repeat (2) step();

        // Both requesters held for three transactions each.
        fork
            for (int k = 0; k < 3; k++) if_txn(AW'(16'h0100 + k), k < 2);
            for (int k = 0; k < 3; k++) da_txn(1'b0, 1'b0, AW'(16'h0200 + k), '0, k < 2);
        join
        repeat (2) step();

        // DA word write whose inputs change once the access is running.
        e.we = 1; e.half = 0; e.addr = 15'h1234; e.wdata = 32'hCAFE0001; e.rdata = '0;
        q_da.push_back(e);
        arb_if.da_we = 1; arb_if.da_half = 0;
        arb_if.da_addr = e.addr; arb_if.da_wdata = e.wdata; arb_if.da_req = 1;
        @(posedge clk);
        step();
        arb_if.da_addr = 15'h4321; arb_if.da_wdata = 32'h0BADF00D;
        wait_ack(1'b1);
        step();
        arb_if.da_req = 0;
        repeat (4) step();

        // Reset during the third cycle of a write: port released at once, no ack.
        arb_if.da_we = 1; arb_if.da_half = 0; arb_if.da_addr = 15'h0777;
        arb_if.da_wdata = 32'h77777777; arb_if.da_req = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_mem_write", 32'(arb_if.mem_write), 32'(MEMW_WORD));
        rst = 1;
        #1;
        chk("rst_abort_mem_write", 32'(arb_if.mem_write), 0);
        chk("rst_abort_bus_oe", 32'(arb_if.bus_oe), 0);
        arb_if.da_req = 0;
        repeat (2) @(posedge clk);
        #3 rst = 0;
        repeat (3) step();
        r = cyc;
        if_txn(15'h7FFF, 1'b0);
        chk("if_after_rst_latency", last_ack_cyc - r, ACC + 2);
        repeat (2) step();

        // Continuous IF requests: acks evenly spaced.
        if_ack_cycles.delete();
        for (int k = 0; k < 5; k++) if_txn(AW'($urandom), k < 4);
        chk("if_ack_count", if_ack_cycles.size(), 5);
        for (int k = 1; k < if_ack_cycles.size(); k++)
            chk("if_ack_spacing", if_ack_cycles[k] - if_ack_cycles[k-1], ACC + 2);
        repeat (2) step();

        // Random traffic from both requesters.
        fork
            for (int k = 0; k < 30; k++) begin
                int g;
                g = $urandom_range(0, 3);
                if_txn(AW'($urandom), (g == 0) && (k < 29));
                repeat (g) step();
            end
            for (int k = 0; k < 30; k++) begin
                int g;
                g = $urandom_range(0, 3);
                da_txn(1'($urandom), 1'($urandom), AW'($urandom), $urandom, (g == 0) && (k < 29));
                repeat (g) step();
            end
        join
        repeat (4) step();
        chk("if_queue_drained", q_if.size(), 0);
        chk("da_queue_drained", q_da.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem16_arbiter.md
Name: mem16_arbiter

Overview:
- Shares the single 15-bit halfword-addressed, 32-bit-data memory port between two requesters: instruction fetch (IF, read-only) and data access (DA, read/write).
- Sequences each access through the memory's multi-cycle, two-phase protocol: addr/control held for ACC_CYCLES clk, read data captured, one-cycle ack.
- Sits between the CPU front/back ends and the memory block; top level owns the tri-state BUS using bus_oe/bus_wdata/bus_rdata.

Parameters:
- ACC_CYCLES, 4, clk cycles addr/control held per access (min 2, max 15).
- AW, 15, halfword address width.
- DW, 32, data width.

Ports:
- clk  in  1  memory clock
- rst  in  1  reset
- if_req  in  1  IF read request; held until if_ack
- if_addr  in  AW  IF halfword address
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DW  fetched word
- da_req  in  1  DA request; held until da_ack
- da_we  in  1  1 = write, 0 = read
- da_half  in  1  write size: 1 = halfword (da_wdata[15:0]), 0 = word
- da_addr  in  AW  DA halfword address
- da_wdata  in  DW  write data
- da_ack  out  1  one-cycle pulse; da_rdata valid on reads
- da_rdata  out  DW  read word
- mem_read  out  1  to memory Memread
- mem_write  out  2  to memory Memwrite: 0 none, 1 word, 3 halfword
- mem_addr  out  AW  to memory Addrin
- bus_oe  out  1  arbiter drives BUS (writes only)
- bus_wdata  out  DW  BUS drive value
- bus_rdata  in  DW  BUS sampled value

Behaviour:
- Reset (async, active-high): state IDLE, all outputs 0, counter 0, grant owner IF, rr pointer IF.
- States: IDLE, ACCESS, DONE.
- IDLE: if any request, select a winner, latch its addr/we/half/wdata into internal regs, go to ACCESS, count = 0. No request: stay, outputs 0.
- Arbitration, fixed priority (default): DA beats IF. Both requests in the same cycle -> DA.
- ACCESS:
  - mem_addr = latched addr.
  - Read: mem_read = 1, mem_write = 0, bus_oe = 0.
  - Write: mem_write = half ? 3 : 1; mem_read = 0; bus_oe = 1; bus_wdata = latched wdata.
  - count increments each clk; at count == ACC_CYCLES-1, capture bus_rdata (reads) and go to DONE.
- DONE:
  - Drive all mem_* and bus_oe to 0.
  - Pulse the owner's ack for exactly one cycle; rdata register updated for reads, held after.
  - Next cycle IDLE.
  - Requester deasserts or issues a new req on the cycle after ack. A req still high in IDLE is a new request.
- Latency: req seen in IDLE -> ack exactly ACC_CYCLES+2 clk later. Back-to-back accesses: one idle cycle minimum between accesses.
- Inputs changing during ACCESS are ignored (latched copy used). A req dropped mid-access still completes; ack is issued and ignored.
- mem_read and mem_write are never both non-zero. bus_oe is 1 only in ACCESS on writes.
- rst mid-ACCESS: abort immediately, no ack, mem_write = 0 the same instant. A partially written memory word is acceptable.
- if_ack and da_ack are never high together.
- Address wrap (0x7FFF + 1) is the memory's concern; the arbiter passes the address unmodified.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin. On simultaneous requests, the requester not served last wins; the pointer updates on every ack. Single requester is always granted.
- Undefined: fixed priority, DA over IF.

Decomposition:
- Package mem16_pkg:
  - state enum (IDLE, ACCESS, DONE).
  - MEMW_NONE = 2'd0, MEMW_WORD = 2'd1, MEMW_HALF = 2'd3.
  - Owner enum OWN_IF/OWN_DA.
- One sub-module, mem16_arb_pick: combinational winner select from if_req, da_req, rr pointer. Contains the ARB_RR_EN switch.
- FSM and datapath latches stay in mem16_arbiter.

Test Plan:
- IF read only, if_addr = 0x0010, bus_rdata = 0xDEADBEEF:
  - mem_read = 1, mem_addr = 0x0010 for 4 cycles.
  - if_ack 6 cycles after req; if_rdata = 0xDEADBEEF.
- DA halfword write, da_addr = 0x0003, da_wdata = 0x0000ABCD:
  - mem_write = 3, bus_oe = 1, bus_wdata = 0x0000ABCD for 4 cycles.
  - da_ack, then all 0.
- Simultaneous if_req and da_req, both held:
  - Fixed: DA, IF, DA, IF... interleave is not required; DA wins every contested IDLE.
  - ARB_RR_EN: strict alternation, first grant DA after reset.
- DA word write issued, da_addr/da_wdata changed at count 1: memory still sees the original addr/data; ack once.
- rst asserted at count 2 of a write: mem_write = 0 and bus_oe = 0 immediately, no ack. After release, an IF request completes normally.
- Continuous if_req: acks spaced exactly ACC_CYCLES+2 apart (6 with default); mem_read never overlaps mem_write.
